// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier with valid/ready handshake.
// Signed operands are multiplied as magnitudes; the sign is reapplied in the last stage.
module vedic_mult_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag
);

  localparam int H    = WIDTH / 2;
  localparam int IDXW = $clog2(H);

  // Half-width vertical-and-crosswise product: each column k sums x[i]&y[k-i].
  function automatic logic [WIDTH-1:0] vedic_half(input logic [H-1:0] x,
                                                  input logic [H-1:0] y);
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] col;
    int               j;
    acc = '0;
    for (int k = 0; k < 2*H-1; k++) begin
      col = '0;
      for (int i = 0; i < H; i++) begin
        j = k - i;
        if (j >= 0 && j < H)
          col = col + WIDTH'(x[i[IDXW-1:0]] & y[j[IDXW-1:0]]);
      end
      acc = acc + (col << k);
    end
    return acc;
  endfunction

  logic                 adv;

  logic                 s1_valid, s1_neg;
  logic [TAG_W-1:0]     s1_tag;
  logic [WIDTH-1:0]     s1_hh, s1_hl, s1_lh, s1_ll;

  logic                 s2_valid, s2_neg;
  logic [TAG_W-1:0]     s2_tag;
  logic [WIDTH+1:0]     s2_mid;
  logic [H-1:0]         s2_hh_hi, s2_ll_lo;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic                 neg_c;
  logic [WIDTH+1:0]     mid_c;
  logic [2*WIDTH-1:0]   mag_c, prod_c;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // NOTE: every variable assigned in always_comb is given a value on all paths, so no latch is inferred.
  always_comb begin
    a_mag  = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
    b_mag  = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
    neg_c  = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
    mid_c  = (WIDTH+2)'({s1_hh[H-1:0], s1_ll[WIDTH-1:H]})
           + (WIDTH+2)'(s1_hl) + (WIDTH+2)'(s1_lh);
    mag_c  = {s2_hh_hi + H'(s2_mid[WIDTH+1:WIDTH]), s2_mid[WIDTH-1:0], s2_ll_lo};
    prod_c = s2_neg ? -mag_c : mag_c;
  end

  // NOTE: data registers are reset too, so outputs read 0 during reset; sequential state uses <= only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_neg      <= 1'b0;
      s1_tag      <= '0;
      s1_hh       <= '0;
      s1_hl       <= '0;
      s1_lh       <= '0;
      s1_ll       <= '0;
      s2_valid    <= 1'b0;
      s2_neg      <= 1'b0;
      s2_tag      <= '0;
      s2_mid      <= '0;
      s2_hh_hi    <= '0;
      s2_ll_lo    <= '0;
      out_valid   <= 1'b0;
      out_product <= '0;
      out_tag     <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_neg   <= neg_c;
      s1_tag   <= in_tag;
      s1_hh    <= vedic_half(a_mag[WIDTH-1:H], b_mag[WIDTH-1:H]);
      s1_hl    <= vedic_half(a_mag[WIDTH-1:H], b_mag[H-1:0]);
      s1_lh    <= vedic_half(a_mag[H-1:0],     b_mag[WIDTH-1:H]);
      s1_ll    <= vedic_half(a_mag[H-1:0],     b_mag[H-1:0]);

      s2_valid <= s1_valid;
      s2_neg   <= s1_neg;
      s2_tag   <= s1_tag;
      s2_mid   <= mid_c;
      s2_hh_hi <= s1_hh[WIDTH-1:H];
      s2_ll_lo <= s1_ll[H-1:0];

      out_valid <= s2_valid;
      // Result registers only change when a real result lands, so bubbles leave them untouched.
      if (s2_valid) begin
        out_product <= prod_c;
        out_tag     <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed bench for vedic_mult_pipe: reset, corners, streaming, backpressure,
// mid-flight reset and an 8/32-bit width sweep.
module tb_vedic_mult_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [15:0] in_a, in_b;
  logic [3:0]  in_tag, out_tag;
  logic [31:0] out_product;

  logic        v8, r8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [3:0]  t8, ot8;
  logic [15:0] p8;

  logic        v32, r32, s32, ov32, or32;
  logic [31:0] a32, b32;
  logic [3:0]  t32, ot32;
  logic [63:0] p32;

  int tests_run    = 0;
  int tests_failed = 0;

  vedic_mult_pipe #(.WIDTH(16), .TAG_W(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag));

  vedic_mult_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .reset(reset), .in_valid(v8), .in_ready(r8),
    .in_a(a8), .in_b(b8), .in_signed(s8), .in_tag(t8),
    .out_valid(ov8), .out_ready(or8),
    .out_product(p8), .out_tag(ot8));

  vedic_mult_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(r32),
    .in_a(a32), .in_b(b32), .in_signed(s32), .in_tag(t32),
    .out_valid(ov32), .out_ready(or32),
    .out_product(p32), .out_tag(ot32));

  // Reference product for the 16-bit instance, built from native wide arithmetic.
  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b,
                                           input logic s);
    logic signed [63:0] p;
    if (s) p = 64'($signed(a)) * 64'($signed(b));
    else   p = $signed(64'(a) * 64'(b));
    return p[31:0];
  endfunction

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [3:0] t);
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    tests_run++;
    if (out_product !== 32'h0) begin tests_failed++; $display("FAIL reset_out_product: got %h want 0", out_product); end
    tests_run++;
    if (out_tag !== 4'h0) begin tests_failed++; $display("FAIL reset_out_tag: got %h want 0", out_tag); end
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    tests_run++;
    if (ov8 !== 1'b0 || ov32 !== 1'b0) begin tests_failed++; $display("FAIL reset_sweep_valid: got %0b/%0b want 0/0", ov8, ov32); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_unsigned;
    drive16(16'hFFFF, 16'hFFFF, 1'b0, 4'd3);
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL single_in_ready: got %0b want 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      #1;
      tests_run++;
      if (out_valid !== (cyc == 3)) begin
        tests_failed++; $display("FAIL single_latency_c%0d: out_valid %0b want %0b", cyc, out_valid, cyc == 3);
      end
      if (cyc == 3) begin
        tests_run++;
        if (out_product !== 32'hFFFE0001) begin tests_failed++; $display("FAIL single_product: got %h want fffe0001", out_product); end
        tests_run++;
        if (out_tag !== 4'd3) begin tests_failed++; $display("FAIL single_tag: got %0d want 3", out_tag); end
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL single_drain: out_valid %0b want 0", out_valid); end
  endtask

  task automatic test_signed_corners;
    logic [15:0] ta [8] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000,
                            16'h8000, 16'hFFFF, 16'h8000, 16'h0000};
    logic [15:0] tb [8] = '{16'h8000, 16'h0001, 16'h0001, 16'hFFFB,
                            16'h8000, 16'h0001, 16'h0001, 16'hFFFB};
    logic        ts [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [31:0] te [8] = '{32'h40000000, 32'hFFFFFFFF, 32'hFFFF8000, 32'h00000000,
                            32'h40000000, 32'h0000FFFF, 32'h00008000, 32'h00000000};
    int n_in  = 0;
    int n_out = 0;
    for (int c = 0; c < 30 && n_out < 8; c++) begin
      if (n_in < 8) drive16(ta[n_in], tb[n_in], ts[n_in], 4'(n_in));
      else          in_valid = 1'b0;
      #1;
      if (out_valid) begin
        tests_run++;
        if (out_product !== te[n_out] || out_tag !== 4'(n_out)) begin
          tests_failed++;
          $display("FAIL corner_%0d: got %h tag %0d want %h tag %0d", n_out, out_product, out_tag, te[n_out], n_out);
        end
        n_out++;
      end
      if (in_valid && in_ready) n_in++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++;
    if (n_out != 8) begin tests_failed++; $display("FAIL corner_timeout: got %0d results want 8", n_out); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_q [$];
    logic [3:0]  tag_q [$];
    logic [15:0] a, b;
    logic        s;
    int n_in = 0, n_out = 0, last_c = -1, ready_low = 0;
    for (int c = 0; c < 300 && n_out < 100; c++) begin
      if (n_in < 100) begin
        a = 16'($urandom);
        b = 16'($urandom);
        if (n_in % 17 == 0) a = 16'h8000;
        if (n_in % 23 == 0) b = 16'h0000;
        s = 1'($urandom_range(0, 1));
        drive16(a, b, s, 4'(n_in));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!in_ready) ready_low++;
      if (out_valid) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++; $display("FAIL stream_extra: unexpected result %h", out_product);
        end else begin
          if (out_product !== exp_q[0] || out_tag !== tag_q[0]) begin
            tests_failed++;
            $display("FAIL stream_%0d: got %h tag %0d want %h tag %0d", n_out, out_product, out_tag, exp_q[0], tag_q[0]);
          end
          void'(exp_q.pop_front());
          void'(tag_q.pop_front());
        end
        n_out++;
        last_c = c;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_prod(in_a, in_b, in_signed));
        tag_q.push_back(in_tag);
        n_in++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests_run++;
    if (n_out != 100) begin tests_failed++; $display("FAIL stream_count: got %0d want 100", n_out); end
    tests_run++;
    if (last_c != 102) begin tests_failed++; $display("FAIL stream_rate: last result at cycle %0d want 102", last_c); end
    tests_run++;
    if (ready_low != 0) begin tests_failed++; $display("FAIL stream_in_ready: low for %0d cycles want 0", ready_low); end
  endtask

  task automatic test_backpressure;
    logic [15:0] ba [3] = '{16'h0003, 16'hFFFE, 16'h1234};
    logic [15:0] bb [3] = '{16'h0005, 16'h0007, 16'h0010};
    logic        bs [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] be [3] = '{32'h0000000F, 32'hFFFFFFF2, 32'h00012340};
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive16(ba[k], bb[k], bs[k], 4'(10 + k));
      #1;
      tests_run++;
      if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_fill_%0d: in_ready %0b want 1", k, in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests_run++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_product !== be[0] || out_tag !== 4'd10) begin
        tests_failed++;
        $display("FAIL bp_stall_%0d: ready %0b valid %0b got %h tag %0d want 0 1 %h 10",
                 k, in_ready, out_valid, out_product, out_tag, be[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b1 || out_product !== be[k] || out_tag !== 4'(10 + k)) begin
        tests_failed++;
        $display("FAIL bp_drain_%0d: valid %0b got %h tag %0d want 1 %h %0d", k, out_valid, out_product, out_tag, be[k], 10 + k);
      end
      @(negedge clk);
    end
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_dup: out_valid %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive16(16'(100 + k), 16'h0002, 1'b0, 4'(5 + k));
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre: out_valid %0b want 1", out_valid); end
    reset = 1'b1;
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || out_product !== 32'h0 || out_tag !== 4'h0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL rmid_async: valid %0b got %h tag %0d ready %0b want 0 0 0 1", out_valid, out_product, out_tag, in_ready);
    end
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rmid_stale_%0d: out_valid %0b want 0", k, out_valid); end
      @(negedge clk);
    end
    drive16(16'h0003, 16'hFFFF, 1'b1, 4'd9);
    @(negedge clk);
    in_valid = 1'b0;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      #1;
      tests_run++;
      if (out_valid !== (cyc == 3)) begin
        tests_failed++; $display("FAIL rmid_latency_c%0d: out_valid %0b want %0b", cyc, out_valid, cyc == 3);
      end
      if (cyc == 3) begin
        tests_run++;
        if (out_product !== 32'hFFFFFFFD || out_tag !== 4'd9) begin
          tests_failed++; $display("FAIL rmid_product: got %h tag %0d want fffffffd 9", out_product, out_tag);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_param_sweep;
    a8 = 8'hFF; b8 = 8'hFF; s8 = 1'b0; t8 = 4'd1; v8 = 1'b1;
    a32 = 32'hFFFFFFFF; b32 = 32'hFFFFFFFF; s32 = 1'b0; t32 = 4'd1; v32 = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; s8 = 1'b1; t8 = 4'd2;
    a32 = 32'h80000000; b32 = 32'h80000000; s32 = 1'b1; t32 = 4'd2;
    @(negedge clk);
    v8 = 1'b0; v32 = 1'b0;
    @(negedge clk);
    #1;
    tests_run++;
    if (ov8 !== 1'b1 || p8 !== 16'hFE01) begin tests_failed++; $display("FAIL w8_unsigned: valid %0b got %h want 1 fe01", ov8, p8); end
    tests_run++;
    if (ov32 !== 1'b1 || p32 !== 64'hFFFFFFFE00000001) begin
      tests_failed++; $display("FAIL w32_unsigned: valid %0b got %h want 1 fffffffe00000001", ov32, p32);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (ov8 !== 1'b1 || p8 !== 16'h4000 || ot8 !== 4'd2) begin tests_failed++; $display("FAIL w8_signed: valid %0b got %h tag %0d want 1 4000 2", ov8, p8, ot8); end
    tests_run++;
    if (ov32 !== 1'b1 || p32 !== 64'h4000000000000000 || ot32 !== 4'd2) begin
      tests_failed++; $display("FAIL w32_signed: valid %0b got %h tag %0d want 1 4000000000000000 2", ov32, p32, ot32);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; t8 = '0; or8 = 1'b1;
    v32 = 1'b0; a32 = '0; b32 = '0; s32 = 1'b0; t32 = '0; or32 = 1'b1;
    test_reset();
    test_single_unsigned();
    test_signed_corners();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vedic_mult_pipe.md
# vedic_mult_pipe

Parametrised, pipelined Vedic (Urdhva-Tiryagbhyam) multiplier with a valid/ready handshake and per-transaction signed/unsigned mode. Successor to the fixed 16x16 combinational multiplier used in the arithmetic-encoder datapath (range/probability scaling). It computes the product from four half-width sub-products plus a three-operand middle sum, registered across three stages so it closes timing at the encoder clock and stalls cleanly under backpressure.

## Interface
- WIDTH, 16, operand width; power of two, 8..32.
- TAG_W, 4, width of the sideband tag carried alongside each operation; 1..16.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block accepts operands this cycle.
- in_a  input  WIDTH  multiplicand.
- in_b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands/result, 0 = unsigned.
- in_tag  input  TAG_W  opaque sideband, returned with the result.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- out_product  output  2*WIDTH  product (signed or unsigned per in_signed).
- out_tag  output  TAG_W  tag of the operation in out_product.

## Operation
- Transfer on input when in_valid && in_ready; on output when out_valid && out_ready.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready and out_valid only). All stages shift together on adv; when !adv every stage register, valid bit, tag and signed flag holds.
- Bubbles are not compressed: an empty stage advances as an empty stage.
- Stage 1 (S1): if in_signed, convert each operand to magnitude (|x| in WIDTH bits unsigned; -2^(WIDTH-1) maps to 2^(WIDTH-1), which fits); record neg = in_signed && (a_msb ^ b_msb). Split magnitudes into H/L halves (H = W/2 bits). Register the four sub-products HH, HL, LH, LL (each WIDTH bits, computed by the half-width Vedic sub-multiplier), plus neg, tag, valid.
- Stage 2 (S2): mid = {HH[H-1:0], LL[WIDTH-1:H]} + HL + LH, computed in WIDTH+2 bits (no truncation; carry out is 0..2). Register mid, HH[WIDTH-1:H], LL[H-1:0], neg, tag, valid.
- Stage 3 (S3): mag = {HH_hi + mid[WIDTH+1:WIDTH], mid[WIDTH-1:0], LL_lo}; carry into HH_hi never overflows (bound: product < 2^(2*WIDTH)). out_product = neg ? -mag : mag, in 2*WIDTH bits. Register into output.
- Unsigned result is exact modulo nothing (full 2*WIDTH); signed result is exact two's complement, including (-2^(W-1))^2 = 2^(2W-2).
- Zero operand with neg = 1 yields 0 (negation of 0), never a negative-zero pattern.

## Timing
- Latency: 3 cycles from input transfer to out_valid with no backpressure; throughput 1 op/cycle.
- Reset (asserted, any time): all stage valid bits, out_valid, out_product, out_tag and internal data registers to 0 immediately; in-flight operations are discarded, not completed. in_ready = 1 while out_valid = 0.
- First input transfer is permitted on the first clk edge after reset deassertion.
- out_product/out_tag are stable while out_valid && !out_ready.
- Simultaneous input and output transfer in the same cycle is legal and keeps full throughput.
- When out_valid = 0, out_product and out_tag hold their last value (0 after reset); consumers ignore them.

## Test plan
- Reset then single unsigned op, WIDTH=16: a=0xFFFF, b=0xFFFF, tag=3 -> exactly 3 cycles later out_valid=1, out_product=0xFFFE0001, out_tag=3; all outputs 0 during reset.
- Signed corners, WIDTH=16: (-32768)x(-32768) -> 0x40000000; (-1)x(1) -> 0xFFFFFFFF; (-32768)x(1) -> 0xFFFF8000; 0x(-5) -> 0x00000000; same bit patterns with in_signed=0 give 0x40000000, 0x0000FFFF, 0x00008000, 0.
- Back-to-back stream of 100 random ops (mixed signed flag, incrementing tags), out_ready=1 -> one result per cycle, in order, matching reference model, in_ready never low.
- Backpressure: 3 ops in flight, hold out_ready=0 for 5 cycles -> in_ready=0, out_product/out_tag frozen on first result; release -> remaining results emerge on consecutive cycles, none lost or duplicated.
- Reset mid-operation: assert reset with 3 ops in flight and out_ready=0 -> out_valid falls asynchronously, no stale results appear after deassertion; next op completes with latency 3.
- Parameter sweep WIDTH=8 and WIDTH=32: 0xFF x 0xFF -> 0xFE01; 0xFFFFFFFF x 0xFFFFFFFF unsigned -> 0xFFFFFFFE00000001; signed (-2^31)^2 -> 0x4000000000000000.
